reg_access_sequencer: RTL

//  Per-issue-slot front end to the locked register file. Takes one decoded

---
 rtl/reg_seq_pkg.sv | 18 +
 rtl/reg_access_sequencer.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/reg_seq_pkg.sv
// Shared types and port indices for the register-access sequencer.
package reg_seq_pkg;

   typedef enum logic [2:0] {
      IDLE,
      ACQ,
      OPV,
      WB,
      COMMIT,
      REL
   } seq_state_e;

   localparam int PORT_RS   = 0;
   localparam int PORT_RT   = 1;
   localparam int PORT_RD   = 2;
   localparam int SEQ_PORTS = 3;

endpackage

// File: rtl/reg_access_sequencer.sv
// Per-issue-slot lock/operand sequencer for one 3-port slice of the locked register file.
// Optional acquire watchdog enabled by defining REG_SEQ_TIMEOUT_EN.
module reg_access_sequencer
   import reg_seq_pkg::*;
#(
   parameter int NUM_PHY_REGS = 32,
   parameter int ID_WIDTH     = 8,
   parameter int ACQ_TIMEOUT  = 64,
   localparam int AW          = $clog2(NUM_PHY_REGS)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 issue_valid,
   output logic                 issue_ready,
   input  logic [AW-1:0]        issue_rs,
   input  logic [AW-1:0]        issue_rt,
   input  logic [AW-1:0]        issue_rd,
   input  logic                 issue_rs_en,
   input  logic                 issue_rt_en,
   input  logic                 issue_rd_en,
   input  logic [ID_WIDTH-1:0]  issue_id,
   output logic                 op_valid,
   input  logic                 op_ready,
   output logic [31:0]          op_rs_data,
   output logic [31:0]          op_rt_data,
   input  logic                 wb_valid,
   input  logic [31:0]          wb_data,
   output logic [AW-1:0]        port_addr         [SEQ_PORTS],
   output logic [SEQ_PORTS-1:0] port_req_read,
   output logic [SEQ_PORTS-1:0] port_req_write,
   output logic [SEQ_PORTS-1:0] port_write_commit,
   output logic [SEQ_PORTS-1:0] port_release,
   output logic [ID_WIDTH-1:0]  port_issue_id     [SEQ_PORTS],
   output logic [31:0]          port_wdata        [SEQ_PORTS],
   input  logic [31:0]          port_rdata        [SEQ_PORTS],
   input  logic [SEQ_PORTS-1:0] port_grant,
   output logic                 err_timeout
);

   seq_state_e state_q, state_d;

   logic [AW-1:0]        addr_q [SEQ_PORTS];
   logic [SEQ_PORTS-1:0] en_q;
   logic [ID_WIDTH-1:0]  id_q;
   logic [SEQ_PORTS-1:0] got_q;
   logic [31:0]          cap_q  [PORT_RD];
   logic [31:0]          result_q;

   logic                 accept;
   logic                 req_active;
   logic [SEQ_PORTS-1:0] req;
   logic [SEQ_PORTS-1:0] got_now;
   logic                 all_got;
   logic                 acq_expire;
   logic [SEQ_PORTS-1:0] rel_mask;
   logic                 unused_rdata;

   assign accept     = (state_q == IDLE) && issue_valid;
   assign req_active = (state_q == ACQ) || (state_q == OPV) || (state_q == WB) || (state_q == COMMIT);
   assign req        = req_active ? en_q : '0;
   // A grant arriving this cycle counts, so the last grant moves to OPV on the next edge.
   assign got_now    = got_q | (port_grant & req);
   assign all_got    = &(got_now | ~en_q);

   // The rd port is write-only; its read data is never consumed.
   assign unused_rdata = ^port_rdata[PORT_RD];

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int p = 0; p < SEQ_PORTS; p++) addr_q[p] <= '0;
         en_q     <= '0;
         id_q     <= '0;
         result_q <= '0;
      end else begin
         if (accept) begin
            addr_q[PORT_RS] <= issue_rs;
            addr_q[PORT_RT] <= issue_rt;
            addr_q[PORT_RD] <= issue_rd;
            en_q            <= {issue_rd_en, issue_rt_en, issue_rs_en};
            id_q            <= issue_id;
         end
         if ((state_q == WB) && wb_valid) result_q <= wb_data;
      end
   end

   for (genvar p = 0; p < SEQ_PORTS; p++) begin : g_port
      always_ff @(posedge clk) begin
         if (rst || accept)                                    got_q[p] <= 1'b0;
         else if ((state_q == ACQ) && port_grant[p] && req[p]) got_q[p] <= 1'b1;
      end

      if (p != PORT_RD) begin : g_cap
         // Operands are cleared on accept so an unused source reads as zero.
         always_ff @(posedge clk) begin
            if (rst || accept)
               cap_q[p] <= '0;
            else if ((state_q == ACQ) && !got_q[p] && port_grant[p] && req[p])
               cap_q[p] <= port_rdata[p];
         end
      end
   end

`ifdef REG_SEQ_TIMEOUT_EN
   localparam int TW = $clog2(ACQ_TIMEOUT + 1);

   logic [TW-1:0] acq_cnt_q;
   logic          timed_out_q;

   assign acq_expire = (state_q == ACQ) && (acq_cnt_q == TW'(ACQ_TIMEOUT - 1));

   always_ff @(posedge clk) begin
      if (rst || accept) begin
         acq_cnt_q   <= '0;
         timed_out_q <= 1'b0;
      end else if (state_q == ACQ) begin
         acq_cnt_q <= acq_cnt_q + 1'b1;
         if (acq_expire && !all_got) timed_out_q <= 1'b1;
      end
   end

   // An abandoned acquire only hands back the locks it actually obtained.
   assign rel_mask    = timed_out_q ? got_q : en_q;
   assign err_timeout = (state_q == REL) && timed_out_q;
`else
   logic unused_cfg;

   assign unused_cfg  = (ACQ_TIMEOUT != 0);
   assign acq_expire  = 1'b0;
   assign rel_mask    = en_q;
   assign err_timeout = 1'b0;
`endif

   assign op_rs_data = cap_q[PORT_RS];
   assign op_rt_data = cap_q[PORT_RT];

   // NOTE: every combinational output gets a default first so no path infers a latch.
   always_comb begin
      state_d           = state_q;
      issue_ready       = 1'b0;
      op_valid          = 1'b0;
      port_req_read     = {1'b0, req[PORT_RT], req[PORT_RS]};
      port_req_write    = {req[PORT_RD], 2'b00};
      port_write_commit = '0;
      port_release      = '0;
      for (int p = 0; p < SEQ_PORTS; p++) begin
         port_addr[p]     = (state_q != IDLE) ? addr_q[p] : '0;
         port_issue_id[p] = (state_q != IDLE) ? id_q : '0;
         port_wdata[p]    = '0;
      end

      unique case (state_q)
         IDLE: begin
            issue_ready = 1'b1;
            if (issue_valid) state_d = ACQ;
         end
         ACQ: begin
            if (all_got)         state_d = OPV;
            else if (acq_expire) state_d = REL;
         end
         OPV: begin
            op_valid = 1'b1;
            if (op_ready) state_d = en_q[PORT_RD] ? WB : REL;
         end
         WB: begin
            if (wb_valid) state_d = COMMIT;
         end
         COMMIT: begin
            port_write_commit[PORT_RD] = 1'b1;
            port_wdata[PORT_RD]        = result_q;
            state_d                    = REL;
         end
         REL: begin
            port_release = rel_mask;
            state_d      = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

endmodule
